// File: rtl/ram_responder.sv
// ram_responder: word-organised synchronous RAM that answers ramREN/ramWEN
// requests with a FREE/BUSY/ACCESS/ERROR handshake on ramstate. It inserts
// LAT BUSY cycles before each access so that requester wait logic sees a
// realistic latency.
module ram_responder #(
    parameter int LAT = 2,
    parameter int AW  = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    input  logic        ramREN,
    input  logic        ramWEN,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] RELOAD = (LAT > 0) ? CW'(LAT - 1) : '0;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic            r_keyRen;
    logic            r_keyWen;
    logic [31:0]     r_keyAddr;
    logic [31:0]     r_keyStore;
    logic [31:0]     r_load;
    logic [31:0]     r_mem [DEPTH];

    state_t          w_nextState;
    logic [CW-1:0]   w_nextCount;
    logic            w_latchKey;
    logic            w_commit;
    logic            w_req;
    logic            w_illegal;
    logic            w_legal;
    logic            w_keySame;
    logic [AW-1:0]   w_idx;

    assign w_req     = ramREN | ramWEN;
    assign w_illegal = (ramREN & ramWEN) | (w_req & (ramaddr[1:0] != 2'b00));
    assign w_legal   = w_req & ~w_illegal;
    assign w_idx     = ramaddr[AW+1:2];

    // Store data only matters for writes, so a read key ignores ramstore.
    assign w_keySame = (ramREN == r_keyRen) && (ramWEN == r_keyWen) &&
                       (ramaddr == r_keyAddr) &&
                       (!ramWEN || (ramstore == r_keyStore));

    // Next-state logic: accepts, restarts, commits and error handling.
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_latchKey  = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (!w_req) begin
                    w_nextState = S_IDLE;
                end else if (w_illegal) begin
                    w_nextState = S_ERR;
                end else if ((r_state == S_DONE) && w_keySame) begin
                    w_nextState = S_DONE;
                end else if (LAT > 0) begin
                    w_nextState = S_WAIT;
                    w_nextCount = RELOAD;
                    w_latchKey  = 1'b1;
                end else begin
                    w_nextState = S_DONE;
                    w_latchKey  = 1'b1;
                    w_commit    = 1'b1;
                end
            end
            S_WAIT: begin
                if (!w_req) begin
                    w_nextState = S_IDLE;
                end else if (w_illegal) begin
                    w_nextState = S_ERR;
                end else if (!w_keySame) begin
                    w_nextCount = RELOAD;
                    w_latchKey  = 1'b1;
                end else if (r_count == '0) begin
                    w_nextState = S_DONE;
                    w_commit    = 1'b1;
                end else begin
                    w_nextCount = r_count - 1'b1;
                end
            end
            S_ERR: begin
                if (!w_illegal) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // State, latency counter and latched request key.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_keyRen   <= 1'b0;
            r_keyWen   <= 1'b0;
            r_keyAddr  <= '0;
            r_keyStore <= '0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            if (w_latchKey) begin
                r_keyRen   <= ramREN;
                r_keyWen   <= ramWEN;
                r_keyAddr  <= ramaddr;
                r_keyStore <= ramstore;
            end
        end
    end

    // Memory array and read register; the op commits only on entry to DONE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_load <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            if (ramWEN) begin
                r_mem[w_idx] <= ramstore;
            end else begin
                r_load <= r_mem[w_idx];
            end
        end
    end

    // Handshake encoding seen by the requester.
    always_comb begin
        ramstate = FREE;
        case (r_state)
            S_IDLE:  ramstate = FREE;
            S_WAIT:  ramstate = BUSY;
            S_DONE:  ramstate = ACCESS;
            S_ERR:   ramstate = ERROR;
            default: ramstate = FREE;
        endcase
    end

    assign ramload = r_load;

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed checks of the RAM responder handshake, latency,
// restart, error and reset behaviour with LAT=2 and LAT=0 instances.
module tb_ram_responder;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic        CLK;
    logic        nRST;
    logic [31:0] addr2, store2, load2;
    logic        ren2, wen2;
    logic [1:0]  state2;
    logic [31:0] addr0, store0, load0;
    logic        ren0, wen0;
    logic [1:0]  state0;

    int errors;
    int checks;

    ram_responder #(.LAT(2), .AW(8)) dut (
        .CLK(CLK), .nRST(nRST), .ramaddr(addr2), .ramstore(store2),
        .ramREN(ren2), .ramWEN(wen2), .ramload(load2), .ramstate(state2)
    );

    ram_responder #(.LAT(0), .AW(8)) dut0 (
        .CLK(CLK), .nRST(nRST), .ramaddr(addr0), .ramstore(store0),
        .ramREN(ren0), .ramWEN(wen0), .ramload(load0), .ramstate(state0)
    );

    // Free-running 10-unit clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic ren, input logic wen,
                                 input logic [31:0] addr, input logic [31:0] store);
        ren2   = ren;
        wen2   = wen;
        addr2  = addr;
        store2 = store;
    endtask

    task automatic applyStimulusLat0(input logic ren, input logic wen,
                                     input logic [31:0] addr, input logic [31:0] store);
        ren0   = ren;
        wen0   = wen;
        addr0  = addr;
        store0 = store;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Steps until the LAT=2 instance shows ACCESS, bounded to 10 cycles.
    task automatic waitAccess(input string tag);
        int n;
        n = 0;
        while (state2 !== ACCESS && n < 10) begin
            step();
            n++;
        end
        checkOutput(tag, {30'd0, state2}, {30'd0, ACCESS});
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b0, 1'b1, addr, data);
        waitAccess("write_access");
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        nRST = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulusLat0(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("reset_state", {30'd0, state2}, {30'd0, FREE});
        checkOutput("reset_load", load2, 32'h0);
        step();
        step();
        nRST = 1'b1;
        step();

        // Read with LAT=2 from an untouched word.
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
        checkOutput("rd_first_free", {30'd0, state2}, {30'd0, FREE});
        step();
        checkOutput("rd_busy1", {30'd0, state2}, {30'd0, BUSY});
        step();
        checkOutput("rd_busy2", {30'd0, state2}, {30'd0, BUSY});
        step();
        checkOutput("rd_access", {30'd0, state2}, {30'd0, ACCESS});
        checkOutput("rd_load0", load2, 32'h0);
        step();
        checkOutput("rd_access_hold", {30'd0, state2}, {30'd0, ACCESS});
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        checkOutput("rd_drop_free", {30'd0, state2}, {30'd0, FREE});

        // Write then read back, plus neighbour word still zero.
        applyStimulus(1'b0, 1'b1, 32'h20, 32'hDEADBEEF);
        step();
        checkOutput("wr_busy1", {30'd0, state2}, {30'd0, BUSY});
        step();
        checkOutput("wr_busy2", {30'd0, state2}, {30'd0, BUSY});
        step();
        checkOutput("wr_access", {30'd0, state2}, {30'd0, ACCESS});
        checkOutput("wr_load_unchanged", load2, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
        step();
        step();
        checkOutput("rb_busy", {30'd0, state2}, {30'd0, BUSY});
        step();
        checkOutput("rb_access", {30'd0, state2}, {30'd0, ACCESS});
        checkOutput("rb_data", load2, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 32'h24, 32'h0);
        step();
        checkOutput("rd24_busy", {30'd0, state2}, {30'd0, BUSY});
        step();
        step();
        checkOutput("rd24_access", {30'd0, state2}, {30'd0, ACCESS});
        checkOutput("rd24_data", load2, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Held write in DONE must not be repeated.
        applyStimulus(1'b0, 1'b1, 32'h30, 32'h1);
        step();
        step();
        step();
        checkOutput("hold_access0", {30'd0, state2}, {30'd0, ACCESS});
        dut.r_mem[12] = 32'h0;
        for (int i = 1; i < 5; i++) begin
            step();
            checkOutput($sformatf("hold_access%0d", i), {30'd0, state2}, {30'd0, ACCESS});
        end
        checkOutput("hold_no_rewrite", dut.r_mem[12], 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Abort and restart: switching address during BUSY restarts latency.
        doWrite(32'h40, 32'hAAAA5555);
        doWrite(32'h44, 32'h12345678);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
        step();
        checkOutput("restart_busy_a", {30'd0, state2}, {30'd0, BUSY});
        applyStimulus(1'b1, 1'b0, 32'h44, 32'h0);
        step();
        checkOutput("restart_busy_b", {30'd0, state2}, {30'd0, BUSY});
        step();
        checkOutput("restart_busy_c", {30'd0, state2}, {30'd0, BUSY});
        step();
        checkOutput("restart_access", {30'd0, state2}, {30'd0, ACCESS});
        checkOutput("restart_data", load2, 32'h12345678);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Write abandoned during BUSY leaves memory untouched.
        applyStimulus(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF);
        step();
        checkOutput("abort_wr_busy", {30'd0, state2}, {30'd0, BUSY});
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        checkOutput("abort_wr_free", {30'd0, state2}, {30'd0, FREE});
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
        waitAccess("abort_rd_access");
        checkOutput("abort_rd_data", load2, 32'hAAAA5555);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Illegal requests: both enables, then misaligned address.
        applyStimulus(1'b1, 1'b1, 32'h50, 32'h0);
        step();
        checkOutput("err_both", {30'd0, state2}, {30'd0, ERROR});
        step();
        checkOutput("err_both_hold", {30'd0, state2}, {30'd0, ERROR});
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        checkOutput("err_release", {30'd0, state2}, {30'd0, FREE});
        applyStimulus(1'b1, 1'b0, 32'h13, 32'h0);
        step();
        checkOutput("err_misaligned", {30'd0, state2}, {30'd0, ERROR});
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        checkOutput("err_misaligned_release", {30'd0, state2}, {30'd0, FREE});

        // LAT=0: ACCESS the cycle after the request, no BUSY.
        applyStimulusLat0(1'b0, 1'b1, 32'h10, 32'hCAFEF00D);
        checkOutput("lat0_wr_free", {30'd0, state0}, {30'd0, FREE});
        step();
        checkOutput("lat0_wr_access", {30'd0, state0}, {30'd0, ACCESS});
        applyStimulusLat0(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        applyStimulusLat0(1'b1, 1'b0, 32'h10, 32'h0);
        step();
        checkOutput("lat0_rd_access", {30'd0, state0}, {30'd0, ACCESS});
        checkOutput("lat0_rd_data", load0, 32'hCAFEF00D);
        applyStimulusLat0(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        // Asynchronous reset in the middle of a write.
        applyStimulus(1'b0, 1'b1, 32'h60, 32'h55);
        step();
        checkOutput("arst_busy", {30'd0, state2}, {30'd0, BUSY});
        #2;
        nRST = 1'b0;
        #1;
        checkOutput("arst_free", {30'd0, state2}, {30'd0, FREE});
        checkOutput("arst_load", load2, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        nRST = 1'b1;
        step();
        applyStimulus(1'b1, 1'b0, 32'h60, 32'h0);
        waitAccess("arst_rd_access");
        checkOutput("arst_rd_data", load2, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side end of the controller-to-RAM interface: a word-organised synchronous memory that answers ramREN/ramWEN requests with a ramstate handshake and ramload data.
- Inserts a configurable number of BUSY cycles before ACCESS, so the memory controller's wait logic can be tested under realistic latency.
- Flags illegal requests with ERROR.
- Used as the RAM behind the memory controller in unit and system benches.

Parameters:
- LAT, 2: BUSY cycles inserted before ACCESS; 0 is legal.
- AW, 8: word-index width; memory depth is 2^AW 32-bit words.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ramaddr  in  32  byte address; word index is ramaddr[AW+1:2].
- ramstore  in  32  write data (word_t).
- ramREN  in  1  read request, level, held until ACCESS is seen.
- ramWEN  in  1  write request, level, held until ACCESS is seen.
- ramload  out  32  read data (word_t), registered.
- ramstate  out  2  ramstate_t, decoded from the state register: FREE, BUSY, ACCESS or ERROR.

Behaviour:
- **Reset** (async, nRST=0):
  - state IDLE, so ramstate=FREE.
  - ramload=0; counter=0; all memory words=0.
  - Any in-flight write is dropped and never committed.
- **Request key**: {ramREN, ramWEN, ramaddr, ramstore}. ramstore is compared only when ramWEN=1. The key is latched when a request is accepted.
- **Legal request**: exactly one of ramREN/ramWEN is 1 and ramaddr[1:0]=0. An illegal request is REN&WEN both high, or a misaligned address on a request.
- **IDLE** (ramstate=FREE):
  - no request: stay IDLE.
  - illegal request: go to ERR.
  - legal request, LAT>0: go to WAIT, counter=LAT-1, latch key.
  - legal request, LAT=0: perform the op (see Op commit) and go to DONE.
- **WAIT** (ramstate=BUSY):
  - request dropped (both REN and WEN low): go to IDLE, no op performed.
  - illegal request: go to ERR.
  - key changed: restart by reloading counter=LAT-1, latching the new key and staying in WAIT.
  - counter=0 with key unchanged: perform the op and go to DONE.
  - otherwise: counter decrements.
- **DONE** (ramstate=ACCESS):
  - identical key held: stay in DONE; ramload is stable and a write is NOT repeated.
  - request dropped: go to IDLE.
  - illegal request: go to ERR.
  - new legal key: handled exactly as from IDLE (WAIT with reload, or DONE with a fresh op if LAT=0).
- **ERR** (ramstate=ERROR): stay while the request is illegal. A legal request, or no request, goes to IDLE; a legal request is re-accepted from there.
- **Op commit**: happens at the clock edge that enters DONE.
  - read: ramload <= mem[idx].
  - write: mem[idx] <= ramstore; ramload is unchanged.
- **Latency**: a request first sampled at edge k produces ACCESS in the cycle after edge k+LAT, so the requester sees LAT BUSY cycles then ACCESS. ramstate=FREE during the request's first cycle.
- **Ordering**: a read issued after a committed write to the same word returns the new data.
- **Address range**: ramaddr bits above AW+1 are ignored; addresses alias modulo 2^AW words.

Test Plan:
- **Read with latency (LAT=2)**: after reset, REN=1, addr=0x10 held → ramstate FREE, BUSY, BUSY, then ACCESS. ramload=0 while ACCESS holds.
- **Write then read (LAT=2)**:
  - WEN=1, addr=0x20, store=0xDEADBEEF until ACCESS, then drop.
  - REN=1, addr=0x20 → ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF.
  - A read at 0x24 returns 0.
- **Held DONE / no double write**: write 0x1 to 0x30 and hold for 5 cycles in ACCESS while the bench forces mem[0x30 index] back to 0 after the first ACCESS cycle → word stays 0. ramstate stays ACCESS all 5 cycles.
- **Abort and restart**: REN addr=0x40, switched to addr=0x44 after 1 BUSY → BUSY count restarts and ACCESS arrives 2 cycles after the switch with mem[0x44]. A WEN dropped during BUSY → memory is unchanged.
- **Errors**:
  - REN=WEN=1 → ERROR next cycle and held; release both → FREE.
  - REN addr=0x13 → ERROR.
- **LAT=0 and async reset**: LAT=0 read → ACCESS on the cycle after the request with no BUSY. Assert nRST in the middle of a LAT=2 write → FREE immediately, and a later read of that address returns 0.
